// File: rtl/axi_tx_arbiter_pkg.sv
// Shared constants and helpers for the PCIe AXI-Stream TX path.
// Stream widths, arbiter state encoding and a constant-foldable ceil(log2).
package axi_tx_arbiter_pkg;

  localparam int AXIS_DATA_W = 128;
  localparam int AXIS_USER_W = 4;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_XFER = 1'b1
  } arbState_e;

  // Smallest r with 2**r >= value; used to size index fields from parameters.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/axi_skid_reg.sv
// Two-entry pipeline stage with registered ready on the input side and
// registered valid/data on the output side; shared by TX-side blocks.
module axi_skid_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] inData_i,
  input  logic         inValid_i,
  output logic         inReady_o,
  output logic [W-1:0] outData_o,
  output logic         outValid_o,
  input  logic         outReady_i
);

  logic [W-1:0] head_q, head_d;
  logic [W-1:0] tail_q, tail_d;
  logic [1:0]   count_q, count_d;
  logic         ready_q;
  logic         valid_q;
  logic         push;
  logic         pop;

  // Head always feeds the output; tail only fills while the head is stalled.
  always_comb begin
    push    = inValid_i & ready_q;
    pop     = valid_q & outReady_i;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    case (count_q)
      2'd0: begin
        if (push) begin
          head_d  = inData_i;
          count_d = 2'd1;
        end
      end
      2'd1: begin
        if (push && pop) begin
          head_d = inData_i;
        end else if (push) begin
          tail_d  = inData_i;
          count_d = 2'd2;
        end else if (pop) begin
          count_d = 2'd0;
        end
      end
      default: begin
        if (pop) begin
          head_d  = tail_q;
          count_d = 2'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= 2'd0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      ready_q <= (count_d != 2'd2);
      valid_q <= (count_d != 2'd0);
    end
  end

  assign inReady_o  = ready_q;
  assign outData_o  = head_q;
  assign outValid_o = valid_q;

endmodule

// File: rtl/axi_tx_arbiter.sv
// Packet-level round-robin arbiter sharing one AXI-Stream TX port between
// N_REQ requesters; a grant is held from first beat until tlast is accepted.
module axi_tx_arbiter
  import axi_tx_arbiter_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int DATA_W = AXIS_DATA_W,
  parameter int USER_W = AXIS_USER_W,
  parameter int IDX_W  = clog2(N_REQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_en,
  input  logic [N_REQ*DATA_W-1:0] s_axis_tx_tdata,
  input  logic [N_REQ*USER_W-1:0] s_axis_tx_tuser,
  input  logic [N_REQ-1:0]        s_axis_tx_tlast,
  input  logic [N_REQ-1:0]        s_axis_tx_tvalid,
  output logic [N_REQ-1:0]        s_axis_tx_tready,
  output logic [DATA_W-1:0]       m_axis_tx_tdata,
  output logic [USER_W-1:0]       m_axis_tx_tuser,
  output logic                    m_axis_tx_tlast,
  output logic                    m_axis_tx_tvalid,
  input  logic                    m_axis_tx_tready,
  output logic                    grant_valid,
  output logic [IDX_W-1:0]        grant_idx,
  output logic [15:0]             pkt_count
);

  localparam int SKID_W = USER_W + 1 + DATA_W;

  arbState_e          state_q;
  logic [IDX_W-1:0]   grant_q;
  logic [IDX_W-1:0]   lastGrant_q;
  logic               grantValid_q;
  logic [15:0]        pktCount_q;
  logic [N_REQ-1:0]   cand;
  logic [SKID_W-1:0]  skidInData;
  logic [SKID_W-1:0]  skidOutData;
  logic               skidInValid;
  logic               skidInReady;
  logic               inAccept;
  logic               inLast;
  logic               mLastBeat;

  // First requester in cand after 'last', wrapping modulo N_REQ.
  function automatic logic [IDX_W-1:0] rrPick(input logic [N_REQ-1:0] req,
                                              input logic [IDX_W-1:0] last);
    logic [IDX_W-1:0] pick;
    logic             found;
    int               idx;
    pick  = '0;
    found = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = (int'(last) + k) % N_REQ;
      if (!found && req[idx]) begin
        pick  = IDX_W'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  // Only the locked requester is routed into the skid while a TLP is open.
  always_comb begin
    cand             = s_axis_tx_tvalid & req_en;
    s_axis_tx_tready = '0;
    skidInValid      = 1'b0;
    skidInData       = {s_axis_tx_tuser[int'(grant_q)*USER_W +: USER_W],
                        s_axis_tx_tlast[grant_q],
                        s_axis_tx_tdata[int'(grant_q)*DATA_W +: DATA_W]};
    if (state_q == ST_XFER) begin
      s_axis_tx_tready[grant_q] = skidInReady;
      skidInValid               = s_axis_tx_tvalid[grant_q];
    end
    inAccept  = skidInValid & skidInReady;
    inLast    = s_axis_tx_tlast[grant_q];
    mLastBeat = m_axis_tx_tvalid & m_axis_tx_tready & m_axis_tx_tlast;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      grantValid_q <= 1'b0;
      lastGrant_q  <= IDX_W'(N_REQ - 1);
      pktCount_q   <= 16'h0000;
    end else begin
      if (mLastBeat) pktCount_q <= pktCount_q + 16'd1;
      case (state_q)
        ST_IDLE: begin
          if (|cand) begin
            state_q      <= ST_XFER;
            grant_q      <= rrPick(cand, lastGrant_q);
            grantValid_q <= 1'b1;
          end
        end
        default: begin
          if (inAccept && inLast) begin
            state_q      <= ST_IDLE;
            grantValid_q <= 1'b0;
            lastGrant_q  <= grant_q;
          end
        end
      endcase
    end
  end

  axi_skid_reg #(
    .W(SKID_W)
  ) u_skid (
    .clk        (clk),
    .rst        (rst),
    .inData_i   (skidInData),
    .inValid_i  (skidInValid),
    .inReady_o  (skidInReady),
    .outData_o  (skidOutData),
    .outValid_o (m_axis_tx_tvalid),
    .outReady_i (m_axis_tx_tready)
  );

  assign {m_axis_tx_tuser, m_axis_tx_tlast, m_axis_tx_tdata} = skidOutData;
  assign grant_valid = grantValid_q;
  assign grant_idx   = grant_q;
  assign pkt_count   = pktCount_q;

endmodule

// File: tb/tb_axi_tx_arbiter.sv
// Directed bench for axi_tx_arbiter: queue-driven requesters, an output
// monitor that records beats and grants, and hand-derived expected streams.
module tb_axi_tx_arbiter;
  import axi_tx_arbiter_pkg::*;

  localparam int N  = 4;
  localparam int DW = 128;
  localparam int UW = 4;

  typedef struct packed {
    logic          last;
    logic [UW-1:0] user;
    logic [DW-1:0] data;
  } beat_t;

  logic            clk;
  logic            rst;
  logic [N-1:0]    req_en;
  logic [N*DW-1:0] s_tdata;
  logic [N*UW-1:0] s_tuser;
  logic [N-1:0]    s_tlast;
  logic [N-1:0]    s_tvalid;
  logic [N-1:0]    s_tready;
  logic [DW-1:0]   m_tdata;
  logic [UW-1:0]   m_tuser;
  logic            m_tlast;
  logic            m_tvalid;
  logic            m_tready;
  logic            grant_valid;
  logic [1:0]      grant_idx;
  logic [15:0]     pkt_count;

  beat_t        srcQ[N][$];
  beat_t        outQ[$];
  int           outCycle[$];
  int           grantQ[$];
  int           accCount[N];
  logic [N-1:0] accFlags;
  int           cycleNum;
  int           vecCount;
  int           errCount;
  logic         prevStall;
  logic         prevGv;
  beat_t        prevBeat;

  axi_tx_arbiter #(
    .N_REQ(N), .DATA_W(DW), .USER_W(UW), .IDX_W(2)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .req_en           (req_en),
    .s_axis_tx_tdata  (s_tdata),
    .s_axis_tx_tuser  (s_tuser),
    .s_axis_tx_tlast  (s_tlast),
    .s_axis_tx_tvalid (s_tvalid),
    .s_axis_tx_tready (s_tready),
    .m_axis_tx_tdata  (m_tdata),
    .m_axis_tx_tuser  (m_tuser),
    .m_axis_tx_tlast  (m_tlast),
    .m_axis_tx_tvalid (m_tvalid),
    .m_axis_tx_tready (m_tready),
    .grant_valid      (grant_valid),
    .grant_idx        (grant_idx),
    .pkt_count        (pkt_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic beat_t mkBeat(input int req, input int n, input logic last);
    beat_t b;
    b.data = {32'hA5A50000 + 32'(req), 32'(n), 32'hDEADBEEF, 32'(req * 16 + n)};
    b.user = 4'(n * 3 + req);
    b.last = last;
    return b;
  endfunction

  task automatic checkOutput(input string tag, input logic [135:0] observed,
                             input logic [135:0] expected);
    vecCount++;
    if (observed !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Queue one TLP of nBeats on requester req, sequence numbers from seq0.
  task automatic applyStimulus(input int req, input int nBeats, input int seq0);
    for (int n = 0; n < nBeats; n++)
      srcQ[req].push_back(mkBeat(req, seq0 + n, n == nBeats - 1));
  endtask

  task automatic waitCycle();
    @(negedge clk);
    #1;
  endtask

  task automatic waitOut(input int n, input string tag);
    int k;
    k = 0;
    while (outQ.size() < n && k < 300) begin
      waitCycle();
      k++;
    end
    waitCycle();
    checkOutput(tag, 136'(outQ.size() >= n), 136'(1));
  endtask

  task automatic clearAll();
    for (int i = 0; i < N; i++) srcQ[i].delete();
    outQ.delete();
    outCycle.delete();
    grantQ.delete();
  endtask

  // Requester model: pop the head after an observed handshake, present the next.
  initial begin
    s_tvalid = '0;
    s_tdata  = '0;
    s_tuser  = '0;
    s_tlast  = '0;
    forever begin
      @(posedge clk);
      #2;
      for (int i = 0; i < N; i++) begin
        if (accFlags[i] && srcQ[i].size() > 0) begin
          srcQ[i].delete(0);
          accCount[i]++;
        end
        if (srcQ[i].size() > 0) begin
          s_tvalid[i]           = 1'b1;
          s_tdata[i*DW +: DW]   = srcQ[i][0].data;
          s_tuser[i*UW +: UW]   = srcQ[i][0].user;
          s_tlast[i]            = srcQ[i][0].last;
        end else begin
          s_tvalid[i] = 1'b0;
        end
      end
    end
  end

  // Output monitor, sampled two time units before each rising edge.
  initial begin
    prevStall = 1'b0;
    prevGv    = 1'b0;
    prevBeat  = '0;
    accFlags  = '0;
    forever begin
      @(negedge clk);
      #3;
      cycleNum++;
      accFlags = rst ? '0 : (s_tvalid & s_tready);
      if (rst) begin
        prevStall = 1'b0;
        prevGv    = 1'b0;
      end else begin
        checkOutput("ready_onehot", 136'($onehot0(s_tready)), 136'(1));
        if (prevStall) begin
          checkOutput("stall_valid", 136'(m_tvalid), 136'(1));
          checkOutput("stall_data", 136'({m_tlast, m_tuser, m_tdata}), 136'(prevBeat));
        end
        if (m_tvalid && m_tready) begin
          outQ.push_back({m_tlast, m_tuser, m_tdata});
          outCycle.push_back(cycleNum);
        end
        if (grant_valid && !prevGv) grantQ.push_back(int'(grant_idx));
        prevStall = m_tvalid & ~m_tready;
        prevBeat  = {m_tlast, m_tuser, m_tdata};
        prevGv    = grant_valid;
      end
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic pat[7];
    int   base;
    int   k;
    pat      = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    vecCount = 0;
    errCount = 0;
    cycleNum = 0;
    for (int i = 0; i < N; i++) accCount[i] = 0;
    rst      = 1'b1;
    req_en   = '1;
    m_tready = 1'b1;

    // Reset state and two 3-beat TLPs from requesters 0 and 2.
    repeat (3) waitCycle();
    checkOutput("rst_m_tvalid", 136'(m_tvalid), 136'(0));
    checkOutput("rst_m_tdata", 136'({m_tlast, m_tuser, m_tdata}), 136'(0));
    checkOutput("rst_grant_valid", 136'(grant_valid), 136'(0));
    checkOutput("rst_grant_idx", 136'(grant_idx), 136'(0));
    checkOutput("rst_pkt_count", 136'(pkt_count), 136'(0));
    checkOutput("rst_s_tready", 136'(s_tready), 136'(0));
    rst = 1'b0;
    clearAll();
    applyStimulus(0, 3, 0);
    applyStimulus(2, 3, 0);
    waitOut(6, "t1_done");
    for (int b = 0; b < 3; b++) begin
      checkOutput($sformatf("t1_r0_beat%0d", b), 136'(outQ[b]), 136'(mkBeat(0, b, b == 2)));
      checkOutput($sformatf("t1_r2_beat%0d", b), 136'(outQ[b + 3]), 136'(mkBeat(2, b, b == 2)));
    end
    checkOutput("t1_grant0", 136'(grantQ[0]), 136'(0));
    checkOutput("t1_grant1", 136'(grantQ[1]), 136'(2));
    checkOutput("t1_back2back", 136'(outCycle[1] - outCycle[0]), 136'(1));
    checkOutput("t1_bubble", 136'(outCycle[3] - outCycle[2]), 136'(2));
    checkOutput("t1_pkt_count", 136'(pkt_count), 136'(2));

    // All four requesters streaming single-beat TLPs.
    rst = 1'b1;
    repeat (2) waitCycle();
    rst = 1'b0;
    clearAll();
    for (int r = 0; r < N; r++) begin
      applyStimulus(r, 1, 0);
      applyStimulus(r, 1, 1);
    end
    waitOut(8, "t2_done");
    for (int b = 0; b < 8; b++)
      checkOutput($sformatf("t2_beat%0d", b), 136'(outQ[b]), 136'(mkBeat(b % 4, b / 4, 1'b1)));
    for (int g = 0; g < 6; g++)
      checkOutput($sformatf("t2_grant%0d", g), 136'(grantQ[g]), 136'(g % 4));
    for (int b = 1; b < 8; b++)
      checkOutput($sformatf("t2_gap%0d", b), 136'(outCycle[b] - outCycle[b - 1]), 136'(2));
    checkOutput("t2_pkt_count", 136'(pkt_count), 136'(8));

    // Four-beat TLP from requester 1 under a stalling core.
    clearAll();
    applyStimulus(1, 4, 0);
    k = 0;
    while (!m_tvalid && k < 50) begin
      waitCycle();
      k++;
    end
    checkOutput("t3_first_valid", 136'(m_tvalid), 136'(1));
    for (int p = 0; p < 7; p++) begin
      m_tready = pat[p];
      waitCycle();
    end
    m_tready = 1'b1;
    waitOut(4, "t3_done");
    checkOutput("t3_count", 136'(outQ.size()), 136'(4));
    for (int b = 0; b < 4; b++)
      checkOutput($sformatf("t3_beat%0d", b), 136'(outQ[b]), 136'(mkBeat(1, b, b == 3)));
    checkOutput("t3_grant", 136'(grantQ[0]), 136'(1));
    checkOutput("t3_pkt_count", 136'(pkt_count), 136'(9));

    // Lock survives req_en[3] being cleared mid-packet.
    clearAll();
    base = accCount[3];
    applyStimulus(3, 3, 0);
    k = 0;
    while (accCount[3] < base + 1 && k < 50) begin
      waitCycle();
      k++;
    end
    req_en[3] = 1'b0;
    applyStimulus(0, 2, 0);
    waitOut(5, "t4_done");
    for (int b = 0; b < 3; b++)
      checkOutput($sformatf("t4_r3_beat%0d", b), 136'(outQ[b]), 136'(mkBeat(3, b, b == 2)));
    for (int b = 0; b < 2; b++)
      checkOutput($sformatf("t4_r0_beat%0d", b), 136'(outQ[b + 3]), 136'(mkBeat(0, b, b == 1)));
    checkOutput("t4_grant0", 136'(grantQ[0]), 136'(3));
    checkOutput("t4_grant1", 136'(grantQ[1]), 136'(0));
    req_en = '1;

    // Reset with two beats of requester 2 parked in the skid.
    clearAll();
    m_tready = 1'b0;
    base     = accCount[2];
    applyStimulus(2, 5, 0);
    k = 0;
    while (accCount[2] < base + 2 && k < 50) begin
      waitCycle();
      k++;
    end
    checkOutput("t5_skid_full_ready", 136'(s_tready), 136'(0));
    checkOutput("t5_skid_valid", 136'(m_tvalid), 136'(1));
    checkOutput("t5_grant_idx", 136'(grant_idx), 136'(2));
    rst = 1'b1;
    clearAll();
    waitCycle();
    checkOutput("t5_rst_m_tvalid", 136'(m_tvalid), 136'(0));
    checkOutput("t5_rst_grant_valid", 136'(grant_valid), 136'(0));
    checkOutput("t5_rst_s_tready", 136'(s_tready), 136'(0));
    checkOutput("t5_rst_pkt_count", 136'(pkt_count), 136'(0));
    rst      = 1'b0;
    m_tready = 1'b1;
    clearAll();
    applyStimulus(2, 2, 0);
    applyStimulus(0, 2, 0);
    waitOut(4, "t5_done");
    checkOutput("t5_grant0", 136'(grantQ[0]), 136'(0));
    checkOutput("t5_grant1", 136'(grantQ[1]), 136'(2));
    for (int b = 0; b < 2; b++) begin
      checkOutput($sformatf("t5_r0_beat%0d", b), 136'(outQ[b]), 136'(mkBeat(0, b, b == 1)));
      checkOutput($sformatf("t5_r2_beat%0d", b), 136'(outQ[b + 2]), 136'(mkBeat(2, b, b == 1)));
    end
    checkOutput("t5_pkt_count", 136'(pkt_count), 136'(2));

    // Packet counter wrap, preloaded just below the top.
    clearAll();
    force dut.pktCount_q = 16'hFFFE;
    waitCycle();
    release dut.pktCount_q;
    waitCycle();
    checkOutput("t6_preload", 136'(pkt_count), 136'(16'hFFFE));
    applyStimulus(1, 1, 0);
    waitOut(1, "t6_first");
    checkOutput("t6_count_ffff", 136'(pkt_count), 136'(16'hFFFF));
    applyStimulus(1, 1, 1);
    waitOut(2, "t6_second");
    checkOutput("t6_count_wrap", 136'(pkt_count), 136'(16'h0000));

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
    $finish;
  end

endmodule
